// File: rtl/mole_scheduler.sv
// Whack-a-mole game sequencer: picks holes from random bytes, times mole-up windows,
// and keeps hit and miss tallies for the display and score logic.
module mole_scheduler #(
  parameter int TICK_DIV  = 50000,
  parameter int UP_TICKS  = 40,
  parameter int GAP_TICKS = 20,
  parameter int MIN_UP    = 8,
  parameter int MAX_MISS  = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] rand_data,
  input  logic [7:0] hit,
  output logic [7:0] mole_up,
  output logic [7:0] score,
  output logic [7:0] misses,
  output logic       busy,
  output logic       hit_pulse,
  output logic       miss_pulse
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {S_IDLE, S_GAP, S_PICK, S_UP, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   pre_q, pre_d;
  logic [7:0]      tcnt_q, tcnt_d;
  logic [7:0]      uplen_q, uplen_d;
  logic [2:0]      prev_q, prev_d;
  logic [7:0]      mole_q, mole_d;
  logic [7:0]      score_q, score_d;
  logic [7:0]      miss_q, miss_d;
  logic            busy_q, busy_d;
  logic            hp_q, hp_d;
  logic            mp_q, mp_d;

  logic            tick;
  logic            gap_done;
  logic            up_done;
  logic            hit_now;
  logic [2:0]      idx_sel;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Avoid showing the same hole twice in a row.
  function automatic logic [2:0] pick_idx(input logic [7:0] r, input logic [2:0] p);
    if (r[2:0] != p)      return r[2:0];
    else if (r[5:3] != p) return r[5:3];
    else                  return p + 3'd1;
  endfunction

  function automatic logic [7:0] up_length(input logic [7:0] s);
    logic signed [8:0] raw;
    raw = $signed(9'(UP_TICKS)) - $signed({3'b000, s[7:2]});
    if (raw < $signed(9'(MIN_UP))) return 8'(MIN_UP);
    else                           return raw[7:0];
  endfunction

  assign tick     = (pre_q == PW'(TICK_DIV - 1));
  assign gap_done = tick && (tcnt_q == 8'(GAP_TICKS - 1));
  assign up_done  = tick && (tcnt_q == uplen_q - 8'd1);
  assign hit_now  = hit[prev_q];
  assign idx_sel  = pick_idx(rand_data, prev_q);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pre_q   <= '0;
      tcnt_q  <= '0;
      uplen_q <= '0;
      prev_q  <= '0;
      mole_q  <= '0;
      score_q <= '0;
      miss_q  <= '0;
      busy_q  <= 1'b0;
      hp_q    <= 1'b0;
      mp_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      tcnt_q  <= tcnt_d;
      uplen_q <= uplen_d;
      prev_q  <= prev_d;
      mole_q  <= mole_d;
      score_q <= score_d;
      miss_q  <= miss_d;
      busy_q  <= busy_d;
      hp_q    <= hp_d;
      mp_q    <= mp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_GAP;
      S_GAP:          if (gap_done) state_d = S_PICK;
      S_PICK:         state_d = S_UP;
      S_UP: begin
        // A hit landing on the expiry edge takes priority over the miss.
        if (hit_now)      state_d = S_GAP;
        else if (up_done) state_d = (sat_inc(miss_q) == 8'(MAX_MISS)) ? S_DONE : S_GAP;
      end
      default:        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pre_d   = tick ? '0 : pre_q + PW'(1);
    tcnt_d  = tick ? tcnt_q + 8'd1 : tcnt_q;
    uplen_d = uplen_q;
    prev_d  = prev_q;
    mole_d  = mole_q;
    score_d = score_q;
    miss_d  = miss_q;
    hp_d    = 1'b0;
    mp_d    = 1'b0;
    busy_d  = (state_d == S_GAP) || (state_d == S_PICK) || (state_d == S_UP);

    if ((state_d != state_q) && ((state_d == S_GAP) || (state_d == S_UP))) begin
      pre_d  = '0;
      tcnt_d = '0;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        mole_d = '0;
        if (start) begin
          score_d = '0;
          miss_d  = '0;
        end
      end
      S_PICK: begin
        prev_d  = idx_sel;
        mole_d  = 8'd1 << idx_sel;
        uplen_d = up_length(score_q);
      end
      S_UP: begin
        if (hit_now) begin
          score_d = sat_inc(score_q);
          hp_d    = 1'b1;
          mole_d  = '0;
        end else if (up_done) begin
          miss_d  = sat_inc(miss_q);
          mp_d    = 1'b1;
          mole_d  = '0;
        end
      end
      default: ;
    endcase
  end

  assign mole_up    = mole_q;
  assign score      = score_q;
  assign misses     = miss_q;
  assign busy       = busy_q;
  assign hit_pulse  = hp_q;
  assign miss_pulse = mp_q;

endmodule

// File: doc/mole_scheduler.md
# mole_scheduler

Game-sequencing controller for the whack-a-mole datapath. It consumes the 8-bit output of the pseudo-random generator bank and decides which of the 8 holes shows a mole, and when. It times how long each mole stays up and scores hits and misses. It sits between the random generator, the debounced button inputs and the display/score logic, and owns the game state machine.

## Interface
Parameters:
- TICK_DIV, 50000 — clock cycles per game tick.
- UP_TICKS, 40 — base mole-up duration in ticks.
- GAP_TICKS, 20 — empty interval between moles, in ticks.
- MIN_UP, 8 — floor on mole-up duration in ticks.
- MAX_MISS, 3 — misses that end a game.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  level or pulse; sampled only in IDLE/DONE to begin a game.
- rand_data  in  8  random byte from the generator bank; sampled only in PICK.
- hit  in  8  per-hole button strobes, already synchronised and debounced.
- mole_up  out  8  one-hot active hole; all zeros when no mole is up.
- score  out  8  hits this game, saturating at 255.
- misses  out  8  expired moles this game.
- busy  out  1  high in GAP, PICK and UP.
- hit_pulse  out  1  one-cycle strobe per scored hit.
- miss_pulse  out  1  one-cycle strobe per expired mole.

## Operation
- States: IDLE, GAP, PICK, UP, DONE. All outputs are registered.
- Reset (asynchronous) forces these values immediately:
  - state=IDLE; mole_up, score, misses, busy, hit_pulse, miss_pulse = 0.
  - prev_idx=0; prescaler and tick counter = 0.
- **IDLE/DONE**
  - mole_up=0, busy=0; score and misses hold.
  - start=1 → clear score and misses, go to GAP.
- **GAP**
  - Counts GAP_TICKS ticks, then goes to PICK.
- **PICK** (exactly 1 cycle)
  - Index selection:
    - idx = rand_data[2:0].
    - If idx == prev_idx, use rand_data[5:3].
    - If that also equals prev_idx, use (prev_idx+1) mod 8.
  - Load up_len = max(UP_TICKS − score[7:2], MIN_UP). Compute with 9-bit signed arithmetic so there is no underflow.
  - Set prev_idx=idx. Go to UP with mole_up = 1<<idx.
- **UP**
  - hit[idx]=1 on a sampled edge → score+1 (saturating), hit_pulse=1 next cycle, mole_up=0, go to GAP.
  - Hits on other holes are ignored: no score change, no penalty.
  - After up_len ticks with no hit → misses+1, miss_pulse=1, mole_up=0.
    - If the new misses == MAX_MISS, go to DONE; otherwise go to GAP.
  - Hit and timer expiry on the same edge: the hit wins, and misses is unchanged.
- start while in GAP, PICK or UP is ignored.
- **Prescaler**
  - Counts 0..TICK_DIV−1; tick = (count == TICK_DIV−1).
  - Cleared, together with the tick counter, on every entry into GAP or UP.
- score and misses saturate at 255; they never wrap.

## Timing
- start sampled at edge N → busy=1 from cycle N+1.
- GAP lasts exactly GAP_TICKS×TICK_DIV cycles; PICK lasts 1 cycle.
- mole_up first goes high GAP_TICKS×TICK_DIV+1 cycles after edge N.
- UP lasts exactly up_len×TICK_DIV cycles when no hit occurs.
- Hit to response latency is 1 cycle: score, hit_pulse, mole_up=0 and state=GAP all update on the same edge.
- hit_pulse and miss_pulse are high for exactly 1 cycle and are never high together.
- DONE is entered on the edge that records the final miss. busy falls on that same edge.
- Reset asserted mid-UP clears mole_up with no clock edge required. The next game starts only after reset is released and start is sampled.

## Test plan
All scenarios use TICK_DIV=4, UP_TICKS=10, GAP_TICKS=2, MIN_UP=4, MAX_MISS=3.
- **First mole.** rand_data=8'h05 held, start pulsed at edge 0 → mole_up=8'h20 from cycle 9, held for 40 cycles.
- **Hit scoring.** While mole_up=8'h20, drive hit=8'h01 → no effect. Then drive hit=8'h20 → next cycle score=1, hit_pulse=1 for one cycle, mole_up=8'h00, busy=1.
- **Repeat avoidance, prev_idx=5:**
  - rand_data=8'h0D → mole_up=8'h02.
  - rand_data=8'h2D → mole_up=8'h40.
  - rand_data=8'h07 → mole_up=8'h80.
- **Game over.** Three moles expire with no hits → three miss_pulse strobes, misses=3, state DONE, mole_up=0, busy=0. start then clears misses and score.
- **Speed-up and tie-break:**
  - Preload score=24 → UP lasts 16 cycles.
  - score=40 → UP clamps to 16 cycles (MIN_UP).
  - hit[idx] asserted on the expiry edge → score increments and misses is unchanged.
- **Async reset.** Assert reset mid-UP between clock edges → all outputs read 0 immediately. After release, start is required before any mole appears.
